int_seq: RTL

- Interrupt and reset sequencer for the 65C02 microcoded core.
- Synchronises the external IRQ/NMI pins and edge-detects NMI.
- Stretches core reset, then raises the interrupt-take request to the microcode controller on instruction boundaries.
- Supplies the vector low byte and manages WAI (and, optionally, STP) by deasserting RDY.

---
 rtl/int_seq_if.sv | 25 ++
 rtl/int_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/int_seq_if.sv
// Handshake bundle between the interrupt/reset sequencer and the 65C02 microcode controller.
// The slave modport is the sequencer side; the master modport is the core/pin side.
interface int_seq_if;
    logic       irq_n;
    logic       nmi_n;
    logic       I;
    logic       sync;
    logic       ack;
    logic       wai;
    logic       stp;
    logic       cpu_reset;
    logic       take_int;
    logic       rdy;
    logic [7:0] vec_lo;

    modport slave (
        input  irq_n, nmi_n, I, sync, ack, wai, stp,
        output cpu_reset, take_int, rdy, vec_lo
    );

    modport master (
        output irq_n, nmi_n, I, sync, ack, wai, stp,
        input  cpu_reset, take_int, rdy, vec_lo
    );
endinterface

// File: rtl/int_seq.sv
// Interrupt and reset sequencer for the 65C02 microcoded core: pin synchronisers, NMI edge
// detect, reset stretch, interrupt take and WAI stall. Define INT_SEQ_STP_EN to add the STP stop state.
module int_seq #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned RESET_CYCLES = 8
) (
    input  logic      clk,
    input  logic      reset_n,
    int_seq_if.slave  bus
);

    localparam logic [7:0] VEC_NMI   = 8'hFA;
    localparam logic [7:0] VEC_RESET = 8'hFC;
    localparam logic [7:0] VEC_IRQ   = 8'hFE;
    localparam logic [7:0] CNT_LAST  = 8'(RESET_CYCLES - 1);

`ifdef INT_SEQ_STP_EN
    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_RUN   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_RUN   = 3'd2,
        ST_WAIT  = 3'd3
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [7:0]             counter_q, counter_d;
    logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
    logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
    logic                   nmi_prev_q, nmi_prev_d;
    logic                   nmi_pend_q, nmi_pend_d;
    logic                   cpu_reset_q, cpu_reset_d;
    logic                   rdy_q, rdy_d;
    logic [7:0]             vec_lo_q, vec_lo_d;

    logic irq_s;
    logic nmi_s;
    logic irq_req_s;
    logic take_int_s;

    assign irq_s     = irq_sync_q[SYNC_STAGES-1];
    assign nmi_s     = nmi_sync_q[SYNC_STAGES-1];
    assign irq_req_s = ~irq_s & ~bus.I;

`ifndef INT_SEQ_STP_EN
    logic stp_unused_s;
    assign stp_unused_s = bus.stp;
`endif

    // State and all registered outputs; synchronisers preset high so reset looks like idle pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HOLD;
            counter_q   <= 8'd0;
            irq_sync_q  <= '1;
            nmi_sync_q  <= '1;
            nmi_prev_q  <= 1'b1;
            nmi_pend_q  <= 1'b0;
            cpu_reset_q <= 1'b1;
            rdy_q       <= 1'b1;
            vec_lo_q    <= VEC_RESET;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            irq_sync_q  <= irq_sync_d;
            nmi_sync_q  <= nmi_sync_d;
            nmi_prev_q  <= nmi_prev_d;
            nmi_pend_q  <= nmi_pend_d;
            cpu_reset_q <= cpu_reset_d;
            rdy_q       <= rdy_d;
            vec_lo_q    <= vec_lo_d;
        end
    end

    // Next-state selection; a take in RUN outranks WAI/STP presented in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HOLD: begin
                if (counter_q == CNT_LAST) begin
                    state_d = ST_ENTRY;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_ENTRY: begin
                if (bus.ack) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ENTRY;
                end
            end
            ST_RUN: begin
                if (take_int_s) begin
                    state_d = ST_ENTRY;
                end else if (bus.wai) begin
                    state_d = ST_WAIT;
`ifdef INT_SEQ_STP_EN
                end else if (bus.stp) begin
                    state_d = ST_STOP;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (nmi_pend_q || !irq_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT;
                end
            end
`ifdef INT_SEQ_STP_EN
            ST_STOP: state_d = ST_STOP;
`endif
            default: state_d = ST_HOLD;
        endcase
    end

    // Output and datapath next values derived from current and next state.
    always_comb begin
        take_int_s = (state_q == ST_RUN) && bus.sync && (nmi_pend_q || irq_req_s);
        irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], bus.irq_n};
        nmi_sync_d = {nmi_sync_q[SYNC_STAGES-2:0], bus.nmi_n};
        nmi_prev_d = nmi_s;

        // A fresh edge wins over the ack that would retire the previous NMI.
        if (nmi_prev_q && !nmi_s) begin
            nmi_pend_d = 1'b1;
        end else if ((state_q == ST_ENTRY) && bus.ack && (vec_lo_q == VEC_NMI)) begin
            nmi_pend_d = 1'b0;
        end else begin
            nmi_pend_d = nmi_pend_q;
        end

        if (state_q == ST_HOLD) begin
            counter_d = counter_q + 8'd1;
        end else begin
            counter_d = counter_q;
        end

        if (take_int_s) begin
            vec_lo_d = nmi_pend_q ? VEC_NMI : VEC_IRQ;
        end else if (state_q == ST_HOLD) begin
            vec_lo_d = VEC_RESET;
        end else begin
            vec_lo_d = vec_lo_q;
        end

        cpu_reset_d = (state_d == ST_HOLD);

        case (state_d)
            ST_WAIT: rdy_d = 1'b0;
`ifdef INT_SEQ_STP_EN
            ST_STOP: rdy_d = 1'b0;
`endif
            default: rdy_d = 1'b1;
        endcase
    end

    assign bus.cpu_reset = cpu_reset_q;
    assign bus.take_int  = take_int_s;
    assign bus.rdy       = rdy_q;
    assign bus.vec_lo    = vec_lo_q;

endmodule
